instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, byte address width; fetch addresses wrap modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8, memory data width (one memory word per transfer).
REQ-003 Parameter INSTR_BYTES, default 4, memory words per instruction (>=1).
REQ-004 Parameter DEPTH, default 2, prefetch queue entries (power of 2, >=1).
REQ-005 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 mem_req  out  1  memory read request.
REQ-009 mem_adr  out  ADDR_W  read address, equal to fetch_pc + byte_cnt (mod 2^ADDR_W).
REQ-010 mem_ack  in  1  transfer completes in any cycle with mem_req && mem_ack.
REQ-011 memdata  in  DATA_W  read data, valid in the mem_ack cycle.
REQ-012 instr  out  DATA_W*INSTR_BYTES  queue-head instruction; 0 when the queue is empty.
REQ-013 pcvalue  out  ADDR_W  address of the head instruction; 0 when the queue is empty.
REQ-014 instr_valid  out  1  queue not empty.
REQ-015 instr_ready  in  1  consumer pops the head when instr_valid && instr_ready.
REQ-016 redirect  in  1  branch/jump: flush the queue and restart fetch.
REQ-017 redirect_pc  in  ADDR_W  restart address, sampled when redirect=1.
REQ-018 q_count  out  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-019 The FSM SHALL have two states: IDLE (mem_req=0) and FETCH (mem_req=1).
REQ-020 IDLE SHALL go to FETCH on the next edge when q_count<DEPTH.
REQ-021 In FETCH, mem_adr SHALL stay stable until mem_ack.
REQ-022 Each ack SHALL store memdata in lane byte_cnt (lane 0 = bits [DATA_W-1:0]) and increment byte_cnt.
REQ-023 The ack of lane INSTR_BYTES-1 SHALL push {assembled instr, fetch_pc} into the queue, reset byte_cnt to 0, and advance fetch_pc by INSTR_BYTES (mod 2^ADDR_W).
REQ-024 After a push, the FSM SHALL go to IDLE if post-push occupancy equals DEPTH, else stay in FETCH.
REQ-025 A push and a pop in the same cycle SHALL leave q_count unchanged.
REQ-026 A pushed entry SHALL be visible at the head (instr_valid=1) in the cycle after the push edge.
REQ-027 Redirect SHALL override ack, push and pop in the same cycle: the partial instruction is discarded, the queue is emptied, byte_cnt=0, fetch_pc=redirect_pc, and state=FETCH.
REQ-028 After a redirect, instr_valid SHALL be 0 in the following cycle.
REQ-029 A pop when the queue is empty SHALL be ignored.
REQ-030 No push SHALL occur when q_count==DEPTH.

Reset
REQ-031 On a reset edge: state=IDLE, fetch_pc=RESET_PC, byte_cnt=0, queue empty.
REQ-032 Outputs while in reset: mem_req=0, instr_valid=0, q_count=0, instr=0, pcvalue=0, mem_adr=RESET_PC.
REQ-033 Reset SHALL abort any in-progress fetch; the partial instruction is lost.

Structure
REQ-034 Package ifu_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-035 The queue SHALL be a sub-module ifu_queue: parametrised FIFO with sync clear, push, pop and count.
REQ-036 The FSM and instruction assembly register SHALL reside in instr_fetch_unit.

Verification
REQ-037 Release reset at edge 0; hold mem_ack=1 and instr_ready=1; memory[a]=a. Required: mem_req rises after edge 1; instr=32'h03020100 with pcvalue=0x00 valid after edge 5; 32'h07060504 with pcvalue=0x04 valid after edge 9.
REQ-038 Hold mem_ack=0 for 3 cycles while mem_adr=0x01. Required: mem_adr holds 0x01 and mem_req stays 1; first instr_valid arrives 3 cycles later than in REQ-037.
REQ-039 Hold instr_ready=0 with DEPTH=2. Required: after 2 pushes, q_count=2, mem_req=0, mem_adr=0x08. Pulse instr_ready for 1 cycle. Required: q_count=1 and fetch resumes at 0x08.
REQ-040 Assert redirect with redirect_pc=0x40 after 2 bytes have been captured. Required: next cycle instr_valid=0, q_count=0, mem_adr=0x40; then instr=32'h43424140 with pcvalue=0x40.
REQ-041 Redirect to 0xFE. Required: reads from 0xFE, 0xFF, 0x00, 0x01; instr=32'h0100FFFE; next fetch at 0x02.
REQ-042 Assert reset mid-instruction. Required: next cycle mem_req=0 and q_count=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit:
// FSM state encoding and default parameter values.
package ifu_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 8;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int DEPTH_DEF       = 2;
  localparam int RESET_PC_DEF    = 0;

endpackage

// File: rtl/ifu_queue.sv
// Prefetch FIFO: sync clear, push, pop, occupancy count.
// Ports: clk, clear, push/wdata, pop, rdata (0 when empty), empty, full, count.
module ifu_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr;
  logic [PTR_W-1:0] rd;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wr <= nxt(wr);
      if (pop_ok)  rd <= nxt(rd);
      cnt <= cnt + CNT_W'(push_ok)
                 - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear)
      mem[wr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads INSTR_BYTES words per instruction into a prefetch queue.
// Ports: clk/reset, mem_req/adr/ack/memdata, instr/pcvalue/valid/ready, redirect, q_count.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int RESET_PC    = RESET_PC_DEF,
  localparam int IW    = DATA_W * INSTR_BYTES,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] memdata,
  output logic [IW-1:0]     instr,
  output logic [ADDR_W-1:0] pcvalue,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  q_count
);

  localparam int BC_W = INSTR_BYTES > 1 ? $clog2(INSTR_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST = BC_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [BC_W-1:0]   byte_cnt;
  logic [IW-1:0]     asm_q;
  logic [IW-1:0]     asm_d;
  logic              ack;
  logic              last;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [CNT_W-1:0]  q_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [IW-1:0]     q_instr;
  logic [ADDR_W-1:0] q_pc;

  assign ack  = (state == ST_FETCH) & mem_ack;
  assign last = (byte_cnt == LAST);
  // Last lane completes only when it can be pushed.
  assign push = ack & last & ~q_full
              & ~redirect & ~reset;
  assign pop  = instr_ready & ~q_empty;
  assign post_cnt = q_cnt + CNT_W'(1)
                  - CNT_W'(pop);

  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < INSTR_BYTES; i++)
      if (byte_cnt == BC_W'(i))
        asm_d[i*DATA_W +: DATA_W] = memdata;
  end

  always_ff @(posedge clk) begin
    if (ack) asm_q <= asm_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RST_PC;
      byte_cnt <= '0;
    end else if (redirect) begin
      state    <= ST_FETCH;
      fetch_pc <= redirect_pc;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (q_cnt < CNT_W'(DEPTH))
            state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (push) begin
            byte_cnt <= '0;
            fetch_pc <= fetch_pc
                      + ADDR_W'(INSTR_BYTES);
            if (post_cnt == CNT_W'(DEPTH))
              state <= ST_IDLE;
          end else if (ack && !last) begin
            byte_cnt <= byte_cnt + BC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ifu_queue #(
    .WIDTH (IW + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .clear (reset | redirect),
    .push  (push),
    .wdata ({asm_d, fetch_pc}),
    .pop   (instr_ready),
    .rdata ({q_instr, q_pc}),
    .empty (q_empty),
    .full  (q_full),
    .count (q_cnt)
  );

  assign mem_req     = (state == ST_FETCH) & ~reset;
  assign mem_adr     = reset ? RST_PC
                     : fetch_pc + ADDR_W'(byte_cnt);
  assign instr_valid = ~q_empty & ~reset;
  assign instr       = reset ? '0 : q_instr;
  assign pcvalue     = reset ? '0 : q_pc;
  assign q_count     = reset ? '0 : q_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a
// scoreboard of expected {instr, pc} entries.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_adr;
  logic        mem_ack = 1'b0;
  logic [7:0]  memdata;
  logic [31:0] instr;
  logic [7:0]  pcvalue;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [1:0]  q_count;

  int tests = 0;
  int fails = 0;
  logic [39:0] sb [$];

  always #5 clk = ~clk;

  // memory[a] = a
  assign memdata = mem_adr;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_adr     (mem_adr),
    .mem_ack     (mem_ack),
    .memdata     (memdata),
    .instr       (instr),
    .pcvalue     (pcvalue),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .q_count     (q_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(
    input logic [7:0] a
  );
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {b3, b2, b1, a};
  endfunction

  task automatic sb_push(input logic [7:0] a);
    sb.push_back({word_at(a), a});
  endtask

  task automatic expect_head(
    input string tag,
    input int    max,
    input int    want_n
  );
    int n;
    logic [39:0] e;
    n = 0;
    while (!instr_valid && n < max) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(want_n));
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk({tag, "_instr"}, 64'(instr), 64'(e[39:8]));
    chk({tag, "_pc"}, 64'(pcvalue), 64'(e[7:0]));
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    step();
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    // T1: reset values and basic streaming
    step();
    step();
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_cnt", 64'(q_count), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", 64'(pcvalue), 64'd0);
    chk("rst_adr", 64'(mem_adr), 64'd0);
    reset = 1'b0;
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    chk("e0_req", 64'(mem_req), 64'd0);
    step();
    chk("e1_req", 64'(mem_req), 64'd1);
    chk("e1_adr", 64'(mem_adr), 64'd0);
    sb_push(8'h00);
    sb_push(8'h04);
    expect_head("t1_h0", 8, 4);
    step();
    chk("e6_cnt", 64'(q_count), 64'd0);
    chk("e6_instr", 64'(instr), 64'd0);
    chk("e6_pc", 64'(pcvalue), 64'd0);
    step();
    chk("pop_empty", 64'(q_count), 64'd0);
    expect_head("t1_h1", 8, 2);

    // T2: ack stall holds address
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    chk("t2_adr0", 64'(mem_adr), 64'h01);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold", 64'(mem_adr), 64'h01);
      chk("t2_req", 64'(mem_req), 64'd1);
    end
    mem_ack = 1'b1;
    sb_push(8'h00);
    expect_head("t2", 10, 3);

    // T3: back-pressure fills queue
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b0;
    sb_push(8'h00);
    sb_push(8'h04);
    repeat (9) step();
    chk("t3_cnt2", 64'(q_count), 64'd2);
    chk("t3_req0", 64'(mem_req), 64'd0);
    chk("t3_adr", 64'(mem_adr), 64'h08);
    expect_head("t3_h0", 0, 0);
    step();
    chk("t3_idle", 64'(mem_req), 64'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t3_cnt1", 64'(q_count), 64'd1);
    expect_head("t3_h1", 0, 0);
    step();
    chk("t3_resume", 64'(mem_req), 64'd1);
    chk("t3_radr", 64'(mem_adr), 64'h08);

    // T4: redirect mid-instruction
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    repeat (3) step();
    chk("t4_part", 64'(mem_adr), 64'h02);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("t4_valid", 64'(instr_valid), 64'd0);
    chk("t4_cnt", 64'(q_count), 64'd0);
    chk("t4_adr", 64'(mem_adr), 64'h40);
    chk("t4_req", 64'(mem_req), 64'd1);
    sb_push(8'h40);
    expect_head("t4", 8, 4);

    // T5: flush non-empty queue, wrap fetch
    instr_ready = 1'b0;
    chk("t5_cnt1", 64'(q_count), 64'd1);
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    instr_ready = 1'b1;
    chk("t5_valid", 64'(instr_valid), 64'd0);
    chk("t5_cnt0", 64'(q_count), 64'd0);
    chk("t5_a0", 64'(mem_adr), 64'hFE);
    step();
    chk("t5_a1", 64'(mem_adr), 64'hFF);
    step();
    chk("t5_a2", 64'(mem_adr), 64'h00);
    step();
    chk("t5_a3", 64'(mem_adr), 64'h01);
    sb_push(8'hFE);
    step();
    expect_head("t5", 0, 0);
    chk("t5_next", 64'(mem_adr), 64'h02);

    // T6: reset mid-instruction
    step();
    step();
    reset = 1'b1;
    step();
    chk("t6_req", 64'(mem_req), 64'd0);
    chk("t6_cnt", 64'(q_count), 64'd0);
    chk("t6_valid", 64'(instr_valid), 64'd0);
    chk("t6_adr", 64'(mem_adr), 64'h00);
    reset = 1'b0;
    sb.delete();
    step();
    chk("t6_req1", 64'(mem_req), 64'd1);
    chk("t6_adr1", 64'(mem_adr), 64'h00);
    sb_push(8'h00);
    expect_head("t6", 8, 4);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
